uart_axis_cfg: RTL

UART_AXIS_CFG -- requirements
Module: uart_axis_cfg

---
 rtl/uart_axis_cfg.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_axis_cfg.sv
// UART with AXI-Stream byte interfaces on both directions; frame format fixed by parameters.
// TX and RX run independently off a shared 16x oversample tick.
module uart_axis_cfg #(
  parameter int CLK_FREQ  = 1600000,
  parameter int BAUD      = 100000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] s_axis_tdata_i,
  input  logic       s_axis_tvalid_i,
  output logic       s_axis_tready_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       m_axis_tvalid_o,
  input  logic       m_axis_tready_i,
  input  logic       uart_rx_i,
  output logic       uart_tx_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [1:0]    sync_q, sync_d;
  logic          rx_s, rx_prev_q;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    sync_d     = {sync_q[0], uart_rx_i};
    rx_s       = sync_q[1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tick_cnt_q <= '0;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_s;
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  tx_state_e  tx_state_q;
  logic [3:0] tx_tick_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;
  logic       tx_par_q, tx_q, tready_q;
  logic       tx_bit_end;

  assign tx_bit_end = tick && (tx_tick_q == 4'd15);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tready_q   <= 1'b0;
    end else begin
      if (tick) tx_tick_q <= tx_tick_q + 4'd1;
      case (tx_state_q)
        TX_IDLE: begin
          tready_q <= 1'b1;
          tx_q     <= 1'b1;
          if (tready_q && s_axis_tvalid_i) begin
            tx_shift_q <= s_axis_tdata_i & DATA_MASK;
            tx_par_q   <= (^(s_axis_tdata_i & DATA_MASK)) ^ ODD_PAR;
            tx_tick_q  <= '0;
            tready_q   <= 1'b0;
            tx_q       <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: if (tx_bit_end) begin
          tx_state_q <= TX_DATA;
          tx_q       <= tx_shift_q[0];
          tx_bit_q   <= '0;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_q <= '0;
            if (PARITY != 0) begin
              tx_state_q <= TX_PARITY;
              tx_q       <= tx_par_q;
            end else begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end
          end else begin
            tx_bit_q   <= tx_bit_q + 3'd1;
            tx_shift_q <= tx_shift_q >> 1;
            tx_q       <= tx_shift_q[1];
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          tx_state_q <= TX_STOP;
          tx_q       <= 1'b1;
          tx_bit_q   <= '0;
        end
        TX_STOP: if (tx_bit_end) begin
          if (tx_bit_q == LAST_STOP) begin
            tx_state_q <= TX_IDLE;
            tready_q   <= 1'b1;
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx_o       = tx_q;
  assign s_axis_tready_o = tready_q;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;
  rx_state_e  rx_state_q;
  logic [3:0] rx_tick_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_data_q;
  logic       rx_par_q, rx_perr_q, rx_done_q, frame_err_q, parity_err_q;
  logic       rx_sample;

  assign rx_sample = tick && (rx_tick_q == 4'd15);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_state_q   <= RX_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_data_q    <= '0;
      rx_par_q     <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      if (tick) rx_tick_q <= rx_tick_q + 4'd1;
      case (rx_state_q)
        RX_IDLE: if (rx_prev_q && !rx_s) begin
          rx_state_q <= RX_START;
          rx_tick_q  <= '0;
        end
        // Half a bit in: still low means a real start bit, otherwise a glitch.
        RX_START: if (tick && (rx_tick_q == 4'd7)) begin
          if (!rx_s) begin
            rx_state_q <= RX_DATA;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
          end else begin
            rx_state_q <= RX_IDLE;
          end
        end
        RX_DATA: if (rx_sample) begin
          rx_data_q[rx_bit_q] <= rx_s;
          rx_par_q            <= rx_par_q ^ rx_s;
          if (rx_bit_q == LAST_DATA) rx_state_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
          else                       rx_bit_q   <= rx_bit_q + 3'd1;
        end
        RX_PARITY: if (rx_sample) begin
          rx_perr_q  <= ((rx_par_q ^ rx_s) != ODD_PAR);
          rx_state_q <= RX_STOP;
        end
        RX_STOP: if (rx_sample) begin
          if (!rx_s) begin
            frame_err_q <= 1'b1;
            rx_state_q  <= RX_WAIT_HIGH;
          end else begin
            if (rx_perr_q) parity_err_q <= 1'b1;
            else           rx_done_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
          end
        end
        RX_WAIT_HIGH: if (rx_s) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Output holding register; a completed frame is dropped if the old byte is still stalled.
  logic [7:0] m_data_q;
  logic       m_valid_q, overrun_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (m_valid_q && m_axis_tready_i) m_valid_q <= 1'b0;
      if (rx_done_q) begin
        if (m_valid_q && !m_axis_tready_i) begin
          overrun_q <= 1'b1;
        end else begin
          m_valid_q <= 1'b1;
          m_data_q  <= rx_data_q;
        end
      end
    end
  end

  assign m_axis_tdata_o  = m_data_q;
  assign m_axis_tvalid_o = m_valid_q;
  assign frame_err_o     = frame_err_q;
  assign parity_err_o    = parity_err_q;
  assign overrun_o       = overrun_q;

endmodule
